// File: rtl/stage_banner_controller_pkg.sv
// Shared definitions for the stage banner controller: FSM state type,
// screen geometry and default banner placement/timing.
package stage_banner_controller_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned DEF_HOLD_CYCLES  = 50_000_000;
    localparam int unsigned DEF_BANNER_X0    = 39;
    localparam int unsigned DEF_BANNER_Y0    = 39;
    localparam int unsigned DEF_BANNER_W     = 80;
    localparam int unsigned DEF_BANNER_H     = 40;
    localparam logic [8:0]  DEF_ERASE_COLOUR = 9'h000;

    // Drawer latency: one reset-release delay cycle plus one ROM read cycle,
    // so its first valid pixel appears on the third DRAW cycle (count == 2).
    localparam logic [1:0] DRAW_LEAD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAW   = 3'd1,
        ST_HOLD   = 3'd2,
        ST_ERASE  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/stage_banner_controller_rect_sweep.sv
// rect_sweep_counter: raster-order sweep of a W x H rectangle, x inner,
// y outer, advancing one position per enabled cycle and wrapping to (0,0)
// after the last position.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   en          advance one position this cycle
//   x, y        current position inside the rectangle
//   last        high while at (W-1, H-1)
module rect_sweep_counter
    import stage_banner_controller_pkg::*;
#(
    parameter int unsigned W = DEF_BANNER_W,
    parameter int unsigned H = DEF_BANNER_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    if (W < 1 || H < 1 || W > SCREEN_W || H > SCREEN_H) begin : g_bad_size
        $error("rect_sweep_counter: rectangle does not fit the screen");
    end

    logic x_end;

    assign x_end = (x == 8'(W - 1));
    assign last  = x_end && (y == 7'(H - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_end) begin
                x <= '0;
                y <= last ? '0 : y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/stage_banner_controller.sv
// stage_banner_controller: shows the "stage start" banner. Releases the ROM
// banner drawer and forwards its pixels to the VGA write port, holds the
// banner for HOLD_CYCLES, optionally erases the banner rectangle, then
// pulses stage_go to hand over to gameplay.
// Build option: define BANNER_ERASE_EN to include the erase sweep; without
// it the banner is left on screen and HOLD goes straight to FINISH.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   stage_start          1-cycle request, honoured only when idle
//   stage_id / stage_sel stage number in / latched banner ROM select out
//   drw_done/x/y/colour  drawer pixel stream and done flag
//   drw_resetn           drawer reset, released only while drawing
//   vga_x/y/colour/plot  VGA adapter write port
//   banner_active        high whenever a sequence is in progress
//   stage_go             1-cycle completion pulse
module stage_banner_controller
    import stage_banner_controller_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int unsigned BANNER_X0    = DEF_BANNER_X0,
    parameter int unsigned BANNER_Y0    = DEF_BANNER_Y0,
    parameter int unsigned BANNER_W     = DEF_BANNER_W,
    parameter int unsigned BANNER_H     = DEF_BANNER_H,
    parameter logic [8:0]  ERASE_COLOUR = DEF_ERASE_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stage_start,
    input  logic [1:0] stage_id,
    input  logic       drw_done,
    input  logic [7:0] drw_x,
    input  logic [6:0] drw_y,
    input  logic [8:0] drw_colour,
    output logic       drw_resetn,
    output logic [1:0] stage_sel,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [8:0] vga_colour,
    output logic       vga_plot,
    output logic       banner_active,
    output logic       stage_go
);

    if (HOLD_CYCLES < 1 || BANNER_X0 + BANNER_W > SCREEN_W ||
        BANNER_Y0 + BANNER_H > SCREEN_H) begin : g_bad_params
        $error("stage_banner_controller: invalid hold time or banner geometry");
    end

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t            state, state_next;
    logic [1:0]        draw_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_last;

    assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

`ifdef BANNER_ERASE_EN
    logic       erase_en;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       erase_last;

    rect_sweep_counter #(
        .W(BANNER_W),
        .H(BANNER_H)
    ) u_erase_sweep (
        .clk  (clk),
        .reset(reset),
        .en   (erase_en),
        .x    (ex),
        .y    (ey),
        .last (erase_last)
    );
`else
    // The erase colour is only consumed by the erase sweep.
    logic [8:0] erase_colour_unused;
    assign erase_colour_unused = ERASE_COLOUR;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            draw_cnt  <= '0;
            hold_cnt  <= '0;
            stage_sel <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && stage_start) begin
                stage_sel <= stage_id;
            end
            // Counts DRAW cycles up to the drawer latency, then saturates.
            if (state == ST_DRAW) begin
                if (draw_cnt != DRAW_LEAD) begin
                    draw_cnt <= draw_cnt + 2'd1;
                end
            end else begin
                draw_cnt <= '0;
            end
            if (state == ST_HOLD && !hold_last) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next    = state;
        drw_resetn    = 1'b0;
        vga_x         = '0;
        vga_y         = '0;
        vga_colour    = '0;
        vga_plot      = 1'b0;
        stage_go      = 1'b0;
        banner_active = (state != ST_IDLE);
`ifdef BANNER_ERASE_EN
        erase_en      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (stage_start) begin
                    state_next = ST_DRAW;
                end
            end
            ST_DRAW: begin
                drw_resetn = 1'b1;
                if (draw_cnt == DRAW_LEAD) begin
                    vga_plot   = 1'b1;
                    vga_x      = drw_x;
                    vga_y      = drw_y;
                    vga_colour = drw_colour;
                    if (drw_done) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
`ifdef BANNER_ERASE_EN
                    state_next = ST_ERASE;
`else
                    state_next = ST_FINISH;
`endif
                end
            end
`ifdef BANNER_ERASE_EN
            ST_ERASE: begin
                erase_en   = 1'b1;
                vga_plot   = 1'b1;
                vga_x      = 8'(BANNER_X0) + ex;
                vga_y      = 7'(BANNER_Y0) + ey;
                vga_colour = ERASE_COLOUR;
                if (erase_last) begin
                    state_next = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                stage_go   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
